// File: rtl/scaler_h.sv
// scaler_h: horizontal linear-interpolation downscaler (scale >= 1.0) with a 3-cycle pipeline.
// Build option SCALER_H_ROUND_EN: round the blend half up instead of truncating.
module scaler_h #(
  parameter int PIXEL_WIDTH      = 8,
  parameter int COE_WIDTH        = 10,
  parameter int STEP_FRAC_WIDTH  = 12,
  parameter int LINE_IN_SIZE_MAX = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            line_in_size,
  input  logic [15:0]            scale_step,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam int CNT_W  = $clog2(LINE_IN_SIZE_MAX) + 1;
  localparam int INT_W  = CNT_W + 1;
  localparam int ACC_W  = INT_W + STEP_FRAC_WIDTH;
  localparam int PROD_W = PIXEL_WIDTH + COE_WIDTH + 1;
  localparam int RES_W  = PROD_W - COE_WIDTH;
  localparam logic [15:0]          STEP_ONE = 16'(2 ** STEP_FRAC_WIDTH);
  localparam logic [COE_WIDTH:0]   COE_ONE  = (COE_WIDTH + 1)'(2 ** COE_WIDTH);
`ifdef SCALER_H_ROUND_EN
  localparam logic [PROD_W-1:0]    ROUND_ADD = PROD_W'(2 ** (COE_WIDTH - 1));
`else
  localparam logic [PROD_W-1:0]    ROUND_ADD = '0;
`endif

  // line state
  logic [CNT_W-1:0]       n_q, n_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [15:0]            step_q, step_d;
  logic [CNT_W-1:0]       size_q, size_d;
  logic [PIXEL_WIDTH-1:0] prev_q, prev_d;

  // pipeline
  logic                   s1_vld_q, s1_vld_d;
  logic [PIXEL_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [PIXEL_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [COE_WIDTH-1:0]   s1_coe_q, s1_coe_d;
  logic                   s2_vld_q;
  logic [PROD_W-1:0]      s2_pa_q, s2_pa_d;
  logic [PROD_W-1:0]      s2_pb_q, s2_pb_d;
  logic [PIXEL_WIDTH-1:0] do_q, do_d;
  logic                   de_q;
  logic [2:0]             hs_dly_q, vs_dly_q;

  logic [15:0]            step_in;
  logic [CNT_W-1:0]       size_in;
  logic [CNT_W-1:0]       n_cur, size_cur;
  logic [ACC_W-1:0]       acc_cur;
  logic [15:0]            step_cur;
  logic [INT_W-1:0]       acc_int, n_ext;
  logic [STEP_FRAC_WIDTH-1:0] frac;
  logic [COE_WIDTH-1:0]   coe;
  logic                   take, hit_exact, hit_blend, emit;
  logic [PROD_W-1:0]      sum;
  logic [RES_W-1:0]       res;

  always_comb begin
    step_in = (scale_step < STEP_ONE) ? STEP_ONE : scale_step;
    size_in = ({16'd0, line_in_size} > 32'(LINE_IN_SIZE_MAX)) ?
              CNT_W'(LINE_IN_SIZE_MAX) : CNT_W'(line_in_size);

    // A pixel arriving with hs_i already belongs to the new line.
    n_cur    = hs_i ? '0 : n_q;
    acc_cur  = hs_i ? '0 : acc_q;
    step_cur = hs_i ? step_in : step_q;
    size_cur = hs_i ? size_in : size_q;

    acc_int = acc_cur[ACC_W-1:STEP_FRAC_WIDTH];
    frac    = acc_cur[STEP_FRAC_WIDTH-1:0];
    coe     = frac[STEP_FRAC_WIDTH-1 -: COE_WIDTH];
    n_ext   = INT_W'(n_cur);

    take      = de_i && (n_cur < size_cur);
    hit_exact = (frac == '0) && (acc_int == n_ext);
    hit_blend = (frac != '0) && ((acc_int + INT_W'(1)) == n_ext);
    emit      = take && (hit_exact || hit_blend);

    n_d    = take ? n_cur + CNT_W'(1) : n_cur;
    acc_d  = emit ? acc_cur + ACC_W'(step_cur) : acc_cur;
    step_d = step_cur;
    size_d = size_cur;
    prev_d = take ? di_i : prev_q;

    // Exact hits blend the current pixel with itself at weight zero.
    s1_vld_d = emit;
    s1_a_d   = hit_exact ? di_i : prev_q;
    s1_b_d   = di_i;
    s1_coe_d = hit_exact ? '0 : coe;

    s2_pa_d = PROD_W'(s1_a_q) * PROD_W'(COE_ONE - {1'b0, s1_coe_q});
    s2_pb_d = PROD_W'(s1_b_q) * PROD_W'(s1_coe_q);

    sum  = s2_pa_q + s2_pb_q + ROUND_ADD;
    res  = sum[PROD_W-1:COE_WIDTH];
    do_d = do_q;
    if (s2_vld_q) begin
      do_d = res[RES_W-1] ? '1 : res[PIXEL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      acc_q    <= '0;
      step_q   <= STEP_ONE;
      size_q   <= '0;
      prev_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_coe_q <= '0;
      s2_vld_q <= 1'b0;
      s2_pa_q  <= '0;
      s2_pb_q  <= '0;
      do_q     <= '0;
      de_q     <= 1'b0;
      hs_dly_q <= '0;
      vs_dly_q <= '0;
    end else begin
      n_q      <= n_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      size_q   <= size_d;
      prev_q   <= prev_d;
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_coe_q <= s1_coe_d;
      s2_vld_q <= s1_vld_q;
      s2_pa_q  <= s2_pa_d;
      s2_pb_q  <= s2_pb_d;
      do_q     <= do_d;
      de_q     <= s2_vld_q;
      hs_dly_q <= {hs_dly_q[1:0], hs_i};
      vs_dly_q <= {vs_dly_q[1:0], vs_i};
    end
  end

  assign do_o = do_q;
  assign de_o = de_q;
  assign hs_o = hs_dly_q[2];
  assign vs_o = vs_dly_q[2];

endmodule

// File: tb/tb_scaler_h.sv
// Randomized bench for scaler_h: output pixels derived from output positions k*step,
// queued at stimulus time and popped by a separate monitor.
module tb_scaler_h;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] line_in_size = '0;
  logic [15:0] scale_step = '0;
  logic [7:0]  di_i = '0;
  logic        de_i = 1'b0;
  logic        hs_i = 1'b0;
  logic        vs_i = 1'b0;
  logic [7:0]  do_o;
  logic        de_o, hs_o, vs_o;

`ifdef SCALER_H_ROUND_EN
  localparam int RND = 512;
`else
  localparam int RND = 0;
`endif

  always #5 clk = ~clk;

  scaler_h dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_in_size (line_in_size),
    .scale_step   (scale_step),
    .di_i         (di_i),
    .de_i         (de_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .do_o         (do_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o)
  );

  typedef struct {
    int unsigned val;
    int unsigned cyc;
  } exp_t;

  exp_t        pix_q[$];
  int unsigned hs_q[$];
  int unsigned vs_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  line_pix [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  always @(negedge clk) begin : mon
    exp_t        e;
    int unsigned t;
    if (rst_n) begin
      if (de_o) begin
        n_checks++;
        if (pix_q.size() == 0) begin
          n_errors++;
          $display("FAIL pixel: unexpected de_o with do_o=%0d at cycle %0d, required no output", do_o, cyc);
        end else begin
          e = pix_q.pop_front();
          if (32'(do_o) != e.val || cyc != e.cyc) begin
            n_errors++;
            $display("FAIL pixel: got do_o=%0d at cycle %0d, required %0d at cycle %0d", do_o, cyc, e.val, e.cyc);
          end
        end
      end
      if (hs_o) begin
        n_checks++;
        if (hs_q.size() == 0) begin
          n_errors++;
          $display("FAIL hs_o: unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          t = hs_q.pop_front();
          if (cyc != t) begin
            n_errors++;
            $display("FAIL hs_o: pulse at cycle %0d, required cycle %0d", cyc, t);
          end
        end
      end
      if (vs_o) begin
        n_checks++;
        if (vs_q.size() == 0) begin
          n_errors++;
          $display("FAIL vs_o: unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          t = vs_q.pop_front();
          if (cyc != t) begin
            n_errors++;
            $display("FAIL vs_o: pulse at cycle %0d, required cycle %0d", cyc, t);
          end
        end
      end
    end
  end

  // Reference: output k sits at position k*step; it is produced by the first input pixel
  // at or beyond that position, provided that pixel lies inside the line.
  task automatic send_line(input int size, input int step, input int npix, input int period,
                           input int gap_pct, input bit coincide, input bit frame);
    bit          trig [0:63];
    int unsigned tval [0:63];
    int          se, pos, ip, f, nn, c, j, idle;
    se = (step < 4096) ? 4096 : step;
    for (int i = 0; i < 64; i++) begin
      trig[i] = 1'b0;
      tval[i] = 0;
    end
    for (int k = 0; k < 64; k++) begin
      pos = k * se;
      ip  = pos / 4096;
      f   = pos % 4096;
      nn  = (f == 0) ? ip : ip + 1;
      if (nn >= size) break;
      trig[nn] = 1'b1;
      if (f == 0) begin
        tval[nn] = 32'(line_pix[nn]);
      end else begin
        c = f / 4;
        tval[nn] = (32'(line_pix[nn-1]) * 32'(1024 - c) + 32'(line_pix[nn]) * 32'(c) + 32'(RND)) / 1024;
        if (tval[nn] > 255) tval[nn] = 255;
      end
    end
    $display("line: size=%0d step=%0d npix=%0d period=%0d gap=%0d hs_with_de=%0d vs=%0d",
             size, step, npix, period, gap_pct, coincide, frame);
    @(negedge clk);
    hs_i = 1'b1;
    vs_i = frame;
    line_in_size = 16'(size);
    scale_step = 16'(step);
    hs_q.push_back(cyc + 3);
    if (frame) vs_q.push_back(cyc + 3);
    j = 0;
    idle = 0;
    if (coincide) begin
      di_i = line_pix[0];
      de_i = 1'b1;
      if (size > 0 && trig[0]) pix_q.push_back('{tval[0], cyc + 3});
      j = 1;
      idle = period - 1;
    end else begin
      de_i = 1'b0;
    end
    while (j < npix) begin
      @(negedge clk);
      hs_i = 1'b0;
      vs_i = 1'b0;
      if (idle > 0) begin
        de_i = 1'b0;
        idle--;
      end else if ($urandom_range(0, 99) < gap_pct) begin
        de_i = 1'b0;
      end else begin
        di_i = line_pix[j];
        de_i = 1'b1;
        if (j < size && trig[j]) pix_q.push_back('{tval[j], cyc + 3});
        j++;
        idle = period - 1;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      de_i = 1'b0;
      hs_i = 1'b0;
      vs_i = 1'b0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_checks++;
    if (do_o !== 8'd0) begin n_errors++; $display("FAIL %s do_o: got %0d, required 0", tag, do_o); end
    n_checks++;
    if (de_o !== 1'b0) begin n_errors++; $display("FAIL %s de_o: got %0b, required 0", tag, de_o); end
    n_checks++;
    if (hs_o !== 1'b0) begin n_errors++; $display("FAIL %s hs_o: got %0b, required 0", tag, hs_o); end
    n_checks++;
    if (vs_o !== 1'b0) begin n_errors++; $display("FAIL %s vs_o: got %0b, required 0", tag, vs_o); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz, st, r;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    // pass-through, back-to-back
    for (int i = 0; i < 8; i++) line_pix[i] = 8'(i + 1);
    send_line(8, 4096, 8, 1, 0, 1'b0, 1'b1);
    idle_cycles(4);
    // 2:1, first pixel together with hs_i
    send_line(8, 8192, 8, 1, 0, 1'b1, 1'b0);
    idle_cycles(4);
    // 1.5:1
    for (int i = 0; i < 8; i++) line_pix[i] = 8'(10 * (i + 1));
    send_line(8, 6144, 8, 1, 0, 1'b0, 1'b0);
    idle_cycles(4);
    // 2:1 with one pixel every four cycles
    for (int i = 0; i < 8; i++) line_pix[i] = 8'(i + 1);
    send_line(8, 8192, 8, 4, 0, 1'b0, 1'b0);
    idle_cycles(4);
    // sub-unity and zero steps clamp to pass-through
    send_line(8, 1024, 8, 1, 0, 1'b0, 1'b0);
    send_line(8, 0, 10, 1, 0, 1'b0, 1'b0);
    idle_cycles(4);
    // half-way blend of 1 and 0
    for (int i = 0; i < 8; i++) line_pix[i] = 8'(i % 2);
    send_line(4, 6144, 4, 1, 0, 1'b0, 1'b0);
    idle_cycles(4);
    // extremes
    for (int i = 0; i < 16; i++) line_pix[i] = (i % 2 == 0) ? 8'd255 : 8'd0;
    send_line(16, 5000, 16, 1, 0, 1'b1, 1'b0);
    idle_cycles(2);

    // randomized lines, some back-to-back
    for (int ln = 0; ln < 40; ln++) begin
      sz = $urandom_range(1, 24);
      r  = $urandom_range(0, 5);
      case (r)
        0: st = 0;
        1: st = $urandom_range(0, 4095);
        2: st = 4096;
        3: st = 8192;
        default: st = $urandom_range(4096, 20000);
      endcase
      for (int i = 0; i < 64; i++) line_pix[i] = 8'($urandom_range(0, 255));
      send_line(sz, st, sz + $urandom_range(0, 3), 1, $urandom_range(0, 50),
                1'($urandom_range(0, 1)), (ln % 8) == 0);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 4));
    end
    idle_cycles(6);

    // asynchronous reset in the middle of a line
    for (int i = 0; i < 8; i++) line_pix[i] = 8'(i + 1);
    send_line(8, 4096, 8, 1, 0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midline_reset");
    pix_q.delete();
    hs_q.delete();
    vs_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      di_i = 8'(50 + i);
      de_i = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    // pixels with no preceding hs_i must be ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      di_i = 8'(90 + i);
      de_i = 1'b1;
    end
    idle_cycles(4);
    send_line(8, 8192, 8, 1, 0, 1'b0, 1'b0);
    idle_cycles(8);

    n_checks++;
    if (pix_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pixels: %0d expected outputs never appeared, required 0", pix_q.size());
    end
    n_checks++;
    if (hs_q.size() != 0 || vs_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain sync: hs pending %0d vs pending %0d, required 0", hs_q.size(), vs_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
